shift_cmd_sequencer: RTL and testbench

SHIFT_CMD_SEQUENCER -- requirements
Module: shift_cmd_sequencer

---
 rtl/shift_cmd_sequencer_if.sv | 28 ++
 rtl/shift_cmd_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_shift_cmd_sequencer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_cmd_sequencer_if.sv
// Handshake bundle between a command source and shift_cmd_sequencer.
// Covers the command push side, the external combinational shifter, the result side and the counter.
// master = environment (source, shifter model, consumer); slave = the sequencer.
interface shift_cmd_sequencer_if;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_nbits;
  logic [7:0] sh_d_in;
  logic [2:0] sh_n_bits;
  logic [7:0] sh_d_out;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] out_nbits;
  logic [7:0] done_cnt;

  modport master (
    output flush, in_valid, in_data, in_nbits, sh_d_out, out_ready,
    input  in_ready, sh_d_in, sh_n_bits, out_valid, out_data, out_nbits, done_cnt
  );

  modport slave (
    input  flush, in_valid, in_data, in_nbits, sh_d_out, out_ready,
    output in_ready, sh_d_in, sh_n_bits, out_valid, out_data, out_nbits, done_cnt
  );
endinterface

// File: rtl/shift_cmd_sequencer.sv
// Queues {word, shift} commands and runs them one at a time through an external combinational shifter.
// Latency: push at edge N -> out_valid after edge N+2; one result per 2 cycles with out_ready held high.
// Backpressure: in_ready = !full (registered); results held until out_ready. Macro SHIFT_SEQ_CNT_EN builds done_cnt.
module shift_cmd_sequencer #(
  parameter int DEPTH = 4  // power of two, 2..16
) (
  input  logic                 clk,
  input  logic                 rst,
  shift_cmd_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] nbits;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, CAPT, HOLD} state_t;

  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          in_ready_q;
  state_t        state_q;
  state_t        state_d;
  logic [7:0]    sh_d_in_q;
  logic [2:0]    sh_n_bits_q;
  logic          out_valid_q;
  logic [7:0]    out_data_q;
  logic [2:0]    out_nbits_q;
  logic          push;
  logic          pop;
  logic          capt;
  logic          accept;
  logic          empty;
  cmd_t          head;

  // A push never bypasses to the pop side: pop only looks at the occupancy before this edge.
  assign empty = (cnt_q == '0);
  assign push  = bus.in_valid && in_ready_q && !bus.flush;
  assign head  = mem_q[rd_ptr_q];

  // Next state and per-edge strobes; flush overrides every handshake.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    capt    = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = CAPT;
        end
      end
      CAPT: begin
        capt    = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (out_valid_q && bus.out_ready) begin
          accept = 1'b1;
          if (!empty) begin
            pop     = 1'b1;
            state_d = CAPT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.flush) begin
      state_d = IDLE;
      pop     = 1'b0;
      capt    = 1'b0;
      accept  = 1'b0;
    end
  end

  // Occupancy update: simultaneous push and pop cancel out.
  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= cmd_t'({bus.in_data, bus.in_nbits});
    end
  end

  // FIFO pointers (wrap naturally at DEPTH), occupancy and registered in_ready.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      in_ready_q <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      cnt_q      <= cnt_d;
      in_ready_q <= (cnt_d != CW'(DEPTH));
    end
  end

  // Shifter operand registers; flush leaves the last operands in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_d_in_q   <= '0;
      sh_n_bits_q <= '0;
    end else if (pop) begin
      sh_d_in_q   <= head.data;
      sh_n_bits_q <= head.nbits;
    end
  end

  // Result capture and hold until the consumer accepts.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_nbits_q <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (capt) begin
      out_valid_q <= 1'b1;
      out_data_q  <= bus.sh_d_out;
      out_nbits_q <= sh_n_bits_q;
    end else if (accept) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef SHIFT_SEQ_CNT_EN
  logic [7:0] done_cnt_q;

  // Completed-result counter: survives flush, cleared only by rst, wraps at 256.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_cnt_q <= '0;
    end else if (accept) begin
      done_cnt_q <= done_cnt_q + 8'd1;
    end
  end

  assign bus.done_cnt = done_cnt_q;
`else
  assign bus.done_cnt = 8'd0;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.sh_d_in   = sh_d_in_q;
  assign bus.sh_n_bits = sh_n_bits_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_nbits = out_nbits_q;
endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Bench for shift_cmd_sequencer: directed scenarios plus randomized traffic against a queue scoreboard.
// The downstream shifter is an 8-bit rotate-left of sh_d_in by sh_n_bits.
// done_cnt is expected to follow the accepted-result count when SHIFT_SEQ_CNT_EN is defined, else 0.
module tb_shift_cmd_sequencer;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  shift_cmd_sequencer_if bus();

  shift_cmd_sequencer #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rotl(input logic [7:0] d, input logic [2:0] n);
    logic [15:0] t;
    t = {d, d} << n;
    return t[15:8];
  endfunction

  assign bus.sh_d_out = rotl(bus.sh_d_in, bus.sh_n_bits);

  // Scoreboard: expected {result, nbits} for every command pushed and not yet accepted.
  logic [10:0] exp_q[$];
  int          done_model = 0;
  int          n_push = 0;
  int          n_acc = 0;
  int          cyc = 0;
  bit          acc_seen;
  logic [10:0] acc_got;
  logic [10:0] acc_exp;

  function automatic logic [7:0] exp_done();
`ifdef SHIFT_SEQ_CNT_EN
    return 8'(done_model);
`else
    return 8'd0;
`endif
  endfunction

  // Records the handshakes that the coming edge will perform, then advances one clock.
  task automatic step();
    acc_seen = 1'b0;
    if (rst || bus.flush) begin
      exp_q.delete();
      if (rst) done_model = 0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        acc_seen = 1'b1;
        acc_got  = {bus.out_data, bus.out_nbits};
        n_acc++;
        done_model++;
        if (exp_q.size() > 0) acc_exp = exp_q.pop_front();
        else acc_exp = 11'bx;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back({rotl(bus.in_data, bus.in_nbits), bus.in_nbits});
        n_push++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.flush = 1'b1; bus.in_valid = 1'b1;
    bus.in_data = 8'hFF; bus.in_nbits = 3'd7; bus.out_ready = 1'b1;
    step(); step();
    rst = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    tests++; if ({bus.out_data, bus.out_nbits} !== 11'd0) begin fails++; $display("FAIL reset_out: got %h/%0d want 0/0", bus.out_data, bus.out_nbits); end
    tests++; if ({bus.sh_d_in, bus.sh_n_bits} !== 11'd0) begin fails++; $display("FAIL reset_sh: got %h/%0d want 0/0", bus.sh_d_in, bus.sh_n_bits); end
    tests++; if (bus.done_cnt !== 8'd0) begin fails++; $display("FAIL reset_done_cnt: got %0d want 0", bus.done_cnt); end
  endtask

  task automatic test_latency();
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'd57; bus.in_nbits = 3'd5;
    step();  // edge N
    bus.in_valid = 1'b0;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL lat_n: out_valid %b want 0", bus.out_valid); end
    step();  // edge N+1
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL lat_n1: out_valid %b want 0", bus.out_valid); end
    tests++; if ({bus.sh_d_in, bus.sh_n_bits} !== {8'd57, 3'd5}) begin fails++; $display("FAIL lat_sh: got %0d/%0d want 57/5", bus.sh_d_in, bus.sh_n_bits); end
    step();  // edge N+2
    tests++; if ({bus.out_valid, bus.out_data, bus.out_nbits} !== {1'b1, 8'h27, 3'd5}) begin
      fails++; $display("FAIL lat_n2: got v=%b %h/%0d want v=1 27/5", bus.out_valid, bus.out_data, bus.out_nbits);
    end
    step();
    tests++; if (!acc_seen || acc_got !== acc_exp) begin fails++; $display("FAIL lat_accept: seen=%b got %h want %h", acc_seen, acc_got, acc_exp); end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL lat_clear: out_valid %b want 0", bus.out_valid); end
  endtask

  // One command goes straight to the shifter, so DEPTH+1 pushes fill the FIFO.
  task automatic test_fill();
    logic [10:0] cmds [DEPTH+1];
    int idx;
    bus.out_ready = 1'b0;
    for (int k = 0; k <= DEPTH; k++) begin
      cmds[k] = 11'($urandom);
      bus.in_valid = 1'b1; {bus.in_data, bus.in_nbits} = cmds[k];
      step();
      tests++; if (bus.in_ready !== logic'(k < DEPTH)) begin fails++; $display("FAIL fill_ready[%0d]: got %b want %b", k, bus.in_ready, k < DEPTH); end
    end
    for (int k = 0; k < 3; k++) begin
      {bus.in_data, bus.in_nbits} = 11'($urandom);
      step();
      tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL fill_full[%0d]: in_ready %b want 0", k, bus.in_ready); end
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    idx = 0;
    for (int c = 0; c < 4 * (DEPTH + 2); c++) begin
      step();
      if (acc_seen) begin
        tests++;
        if (idx > DEPTH || acc_got !== {rotl(cmds[idx][10:3], cmds[idx][2:0]), cmds[idx][2:0]}) begin
          fails++; $display("FAIL fill_order[%0d]: got %h", idx, acc_got);
        end
        idx++;
      end
    end
    tests++; if (idx != DEPTH + 1) begin fails++; $display("FAIL fill_count: got %0d results want %0d", idx, DEPTH + 1); end
    tests++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin fails++; $display("FAIL fill_idle: v=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_hold();
    int wait_c;
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'd69; bus.in_nbits = 3'd1;
    step();
    bus.in_valid = 1'b0;
    wait_c = 0;
    while (bus.out_valid !== 1'b1 && wait_c < 5) begin step(); wait_c++; end
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL hold_timeout: out_valid %b want 1", bus.out_valid); end
    for (int k = 0; k < 5; k++) begin
      tests++; if ({bus.out_valid, bus.out_data, bus.out_nbits} !== {1'b1, 8'h8A, 3'd1}) begin
        fails++; $display("FAIL hold_stable[%0d]: got v=%b %h/%0d want v=1 8a/1", k, bus.out_valid, bus.out_data, bus.out_nbits);
      end
      step();
    end
    bus.out_ready = 1'b1;
    step();
    tests++; if (!acc_seen || acc_got !== {8'h8A, 3'd1}) begin fails++; $display("FAIL hold_accept: seen=%b got %h want 8a/1", acc_seen, acc_got); end
    for (int k = 0; k < 3; k++) begin
      step();
      tests++; if (bus.out_valid !== 1'b0 || acc_seen) begin fails++; $display("FAIL hold_once[%0d]: out_valid %b acc %b want 0", k, bus.out_valid, acc_seen); end
    end
  endtask

  task automatic test_flush();
    logic [10:0] first;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.in_valid = 1'b1; {bus.in_data, bus.in_nbits} = 11'($urandom);
      if (k == 0) first = {bus.in_data, bus.in_nbits};
      step();
    end
    bus.in_valid = 1'b0;
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL flush_pre: out_valid %b want 1", bus.out_valid); end
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1; {bus.in_data, bus.in_nbits} = 11'($urandom);
    step();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    tests++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin fails++; $display("FAIL flush_state: v=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready); end
    tests++; if ({bus.sh_d_in, bus.sh_n_bits} !== first) begin fails++; $display("FAIL flush_sh_keep: got %h want %h", {bus.sh_d_in, bus.sh_n_bits}, first); end
    tests++; if (bus.done_cnt !== exp_done()) begin fails++; $display("FAIL flush_done_cnt: got %0d want %0d", bus.done_cnt, exp_done()); end
    for (int k = 0; k < 6; k++) begin
      step();
      tests++; if (bus.out_valid !== 1'b0 || acc_seen) begin fails++; $display("FAIL flush_silent[%0d]: out_valid %b want 0", k, bus.out_valid); end
    end
  endtask

  task automatic test_random();
    bit held;
    for (int i = 0; i < 600; i++) begin
      bus.in_valid  = ($urandom_range(0, 99) < 60);
      {bus.in_data, bus.in_nbits} = 11'($urandom);
      bus.out_ready = ($urandom_range(0, 99) < 45);
      bus.flush     = ($urandom_range(0, 99) < 2);
      held = bus.out_valid && !bus.out_ready && !bus.flush;
      step();
      if (acc_seen) begin
        tests++; if (acc_got !== acc_exp) begin fails++; $display("FAIL rand_result@%0d: got %h want %h", cyc, acc_got, acc_exp); end
      end
      if (held) begin
        tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL rand_hold@%0d: out_valid %b want 1", cyc, bus.out_valid); end
      end
      if (bus.out_valid) begin
        tests++; if (exp_q.size() == 0 || {bus.out_data, bus.out_nbits} !== exp_q[0]) begin
          fails++; $display("FAIL rand_head@%0d: got %h, %0d pending", cyc, {bus.out_data, bus.out_nbits}, exp_q.size());
        end
      end
      tests++; if (bus.in_ready !== logic'(exp_q.size() <= DEPTH)) begin fails++; $display("FAIL rand_in_ready@%0d: got %b with %0d pending", cyc, bus.in_ready, exp_q.size()); end
      tests++; if (bus.done_cnt !== exp_done()) begin fails++; $display("FAIL rand_done_cnt@%0d: got %0d want %0d", cyc, bus.done_cnt, exp_done()); end
    end
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    for (int c = 0; c < 4 * (DEPTH + 2) && exp_q.size() > 0; c++) begin
      step();
      if (acc_seen) begin
        tests++; if (acc_got !== acc_exp) begin fails++; $display("FAIL rand_drain@%0d: got %h want %h", cyc, acc_got, acc_exp); end
      end
    end
    step();
    tests++; if (exp_q.size() != 0 || bus.out_valid !== 1'b0) begin fails++; $display("FAIL rand_empty: %0d pending, out_valid %b", exp_q.size(), bus.out_valid); end
  endtask

  // 257 results back to back: checks the 2-cycle cadence and counter wrap.
  task automatic test_back_to_back();
    int acc0, push0, last, bad_gaps;
    bit have_last;
    rst = 1'b1; step(); rst = 1'b0;
    bus.out_ready = 1'b1;
    acc0 = n_acc; push0 = n_push; bad_gaps = 0; have_last = 1'b0; last = 0;
    for (int i = 0; i < 1500 && (n_acc - acc0) < 257; i++) begin
      bus.in_valid = ((n_push - push0) < 257);
      {bus.in_data, bus.in_nbits} = 11'($urandom);
      step();
      if (acc_seen) begin
        tests++; if (acc_got !== acc_exp) begin fails++; $display("FAIL b2b_result@%0d: got %h want %h", cyc, acc_got, acc_exp); end
        if (have_last && (cyc - last) != 2) bad_gaps++;
        last = cyc; have_last = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
    tests++; if (n_acc - acc0 != 257) begin fails++; $display("FAIL b2b_count: got %0d results want 257", n_acc - acc0); end
    tests++; if (bad_gaps != 0) begin fails++; $display("FAIL b2b_rate: %0d gaps not equal to 2 cycles", bad_gaps); end
`ifdef SHIFT_SEQ_CNT_EN
    tests++; if (bus.done_cnt !== 8'(n_acc - acc0)) begin fails++; $display("FAIL b2b_done_cnt: got %0d want %0d", bus.done_cnt, 8'(n_acc - acc0)); end
`else
    tests++; if (bus.done_cnt !== 8'd0) begin fails++; $display("FAIL b2b_done_cnt: got %0d want 0", bus.done_cnt); end
`endif
  endtask

  task automatic test_rst_capt();
    step();
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'hA5; bus.in_nbits = 3'd3;
    step();  // push
    bus.in_valid = 1'b0;
    step();  // pop into shifter, now capturing
    tests++; if ({bus.sh_d_in, bus.out_valid} !== {8'hA5, 1'b0}) begin fails++; $display("FAIL rcapt_pre: sh %h v=%b want a5 v=0", bus.sh_d_in, bus.out_valid); end
    rst = 1'b1; bus.flush = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    step();
    rst = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b0;
    tests++; if ({bus.in_ready, bus.out_valid} !== 2'b10) begin fails++; $display("FAIL rcapt_hs: rdy=%b v=%b want 1/0", bus.in_ready, bus.out_valid); end
    tests++; if ({bus.out_data, bus.out_nbits, bus.sh_d_in, bus.sh_n_bits} !== 22'd0) begin
      fails++; $display("FAIL rcapt_regs: out %h/%0d sh %h/%0d want zeros", bus.out_data, bus.out_nbits, bus.sh_d_in, bus.sh_n_bits);
    end
    tests++; if (bus.done_cnt !== 8'd0) begin fails++; $display("FAIL rcapt_done_cnt: got %0d want 0", bus.done_cnt); end
    for (int k = 0; k < 4; k++) begin
      step();
      tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rcapt_discard[%0d]: out_valid %b want 0", k, bus.out_valid); end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.in_nbits = '0; bus.out_ready = 1'b0;
    test_reset();
    test_latency();
    test_fill();
    test_hold();
    test_flush();
    test_random();
    test_back_to_back();
    test_rst_capt();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
